instruction_fetch: RTL
======================

# instruction_fetch

Parametrised instruction fetch unit replacing the single-width program counter. It drives a synchronous-read program ROM (existing `ram`, one-cycle read latency) and presents one instruction per cycle with an explicit valid flag instead of masking with the previous word. It adds stall/hold, jump, call and return with a hardware return-address stack. It sits between program memory and the decode/execute stage of the CPU.

## Interface
- ADDR_WIDTH, 8: program address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16: instruction word width.
- STACK_DEPTH, 8: return-address stack entries, ≥2, power of two.
- RESET_ADDR, 0: first fetch address after reset.
- NOP_WORD, all ones: value of o_instruction whenever o_valid=0.
- PROGRAM_FILENAME, "program.hex": ROM init file passed to `ram`.
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset; one clock, reset synchronous and active-low.
- i_stall  in  1  hold current instruction; do not advance.
- i_load  in  1  jump to i_addr.
- i_call  in  1  push o_addr+1, jump to i_addr.
- i_ret  in  1  pop return address, jump to it.
- i_addr  in  ADDR_WIDTH  jump/call target.
- o_valid  out  1  o_instruction/o_addr are a real fetched instruction.
- o_addr  out  ADDR_WIDTH  address of o_instruction.
- o_instruction  out  DATA_WIDTH  instruction word, NOP_WORD when invalid.
- o_stack_err  out  1  sticky overflow/underflow flag, cleared only by reset.

## Operation
- Reset (i_rst_n=0 at an edge): o_valid=0, o_instruction=NOP_WORD, o_addr=RESET_ADDR, fetch address=RESET_ADDR, stack empty (count 0), o_stack_err=0.
- Sequential: each unstalled valid cycle advances to o_addr+1 (wraps from 2^ADDR_WIDTH−1 to 0) with no bubble.
- Redirect kinds, priority i_ret > i_call > i_load if several asserted; lower ones ignored that cycle.
- i_load honoured regardless of o_valid. i_call/i_ret honoured only when o_valid=1; ignored otherwise.
- Call: push (o_addr+1) mod 2^ADDR_WIDTH, jump to i_addr. Stack full: no push, jump still taken, o_stack_err←1.
- Return: pop top, jump to it. Stack empty: jump to RESET_ADDR, o_stack_err←1.
- Stall: while i_stall=1 and no redirect, o_valid/o_addr/o_instruction hold exactly; fetch does not advance. On release, the next cycle presents o_addr+1 (no bubble); a one-entry skid register is acceptable.
- Redirect overrides stall: taken even with i_stall=1.
- Stall with o_valid=0 (bubble): bubble resolves normally; first valid word is then held while i_stall remains 1.

## Timing
- Redirect sampled at edge N: o_valid=0 / NOP_WORD in cycle after N (one bubble); edge N+1 presents o_instruction=mem[target], o_addr=target, o_valid=1.
- Reset release: first edge with i_rst_n=1 is E0; after E1, o_valid=1, o_addr=RESET_ADDR, o_instruction=mem[RESET_ADDR].
- Back-to-back redirects: each restarts the bubble; only the last target is fetched.
- Stack push/pop take effect at the sampling edge; call immediately followed (first valid cycle of target) by ret returns to caller+1.
- Reset mid-operation: all state returns to reset values at that edge; in-flight ROM data discarded.
- o_stack_err registered, asserts the edge after the faulting call/ret.

## Structure
- Shared package `fetch_pkg`: redirect-kind enum (NONE, LOAD, CALL, RET) and the priority-encode function; NOP_WORD default constant.
- Sub-module `return_stack`: STACK_DEPTH × ADDR_WIDTH LIFO with push/pop, full/empty, count; push+pop same cycle not required (priority prevents it).
- ROM instantiated as existing `ram` with i_load tied 0.

## Test plan
- Reset release, RESET_ADDR=0, ROM[0..3]=A,B,C,D -> o_valid=0 until after E1, then A,B,C,D on consecutive cycles with o_addr 0..3.
- i_load, i_addr=0x40 at edge N -> one cycle o_valid=0, o_instruction=NOP_WORD, then o_addr=0x40, word mem[0x40], then 0x41.
- i_stall high 3 cycles while o_addr=5 -> o_addr=5 and word held 3 cycles, next cycle o_addr=6, no bubble; load during stall taken.
- i_call to 0x20 at o_addr=0x10, then i_ret at 0x22 -> fetch resumes at 0x11; simultaneous i_call+i_load treated as call.
- STACK_DEPTH+1 nested calls -> o_stack_err=1 after the extra call; ret on empty stack -> jump to RESET_ADDR, o_stack_err stays 1 until reset.
- ADDR_WIDTH=8, run from 0xFE -> o_addr sequence 0xFE, 0xFF, 0x00; call at 0xFF pushes 0x00.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// fetch_pkg : redirect kinds, redirect priority encoder, NOP fill constant
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_LOAD = 2'd1,
    REDIR_CALL = 2'd2,
    REDIR_RET  = 2'd3
  } redirect_e;

  // Wide all-ones source; sliced down to the instruction width by the user.
  localparam logic [127:0] c_nop_fill = '1;

  // Call and return need a real instruction to act on; load does not.
  function automatic redirect_e redirect_select(input logic ret, input logic call,
                                                input logic load, input logic valid);
    redirect_e kind;
    kind = REDIR_NONE;
    if (ret && valid)       kind = REDIR_RET;
    else if (call && valid) kind = REDIR_CALL;
    else if (load)          kind = REDIR_LOAD;
    return kind;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// instruction_fetch_if : control/instruction bus between fetch unit and decode
// Rev 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic                  i_stall;
  logic                  i_load;
  logic                  i_call;
  logic                  i_ret;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  o_valid;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_instruction;
  logic                  o_stack_err;

  modport master (
    output i_stall, i_load, i_call, i_ret, i_addr,
    input  o_valid, o_addr, o_instruction, o_stack_err
  );

  modport slave (
    input  i_stall, i_load, i_call, i_ret, i_addr,
    output o_valid, o_addr, o_instruction, o_stack_err
  );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_return_stack.sv
// ============================================================================
// return_stack : DEPTH x WIDTH LIFO holding call return addresses
// Rev 1.0
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_top,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_one   = (c_ptr_w+1)'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w:0]   r_count;
  logic [c_ptr_w:0]   w_top_pos;

  assign w_top_pos = r_count - c_one;
  assign o_top     = r_mem[w_top_pos[c_ptr_w-1:0]];
  // DEPTH is a power of two, so the count MSB alone marks a full stack.
  assign o_full    = r_count[c_ptr_w];
  assign o_empty   = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + c_one;
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - c_one;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[r_count[c_ptr_w-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// ram : single-port synchronous-read memory, one-cycle read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module ram #(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 16,
  parameter     PROGRAM_FILENAME = "program.hex"
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_load,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  output logic      [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // The image named here is bound to r_mem by the memory implementation flow.
  if (PROGRAM_FILENAME == "") begin : g_no_image
  end else begin : g_image
  end

  always_ff @(posedge i_clk) begin
    if (i_load) r_mem[i_addr] <= i_data;
    o_data <= r_mem[i_addr];
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : program counter, ROM fetch, stall, jump/call/return
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int                    ADDR_WIDTH       = 8,
  parameter int                    DATA_WIDTH       = 16,
  parameter int                    STACK_DEPTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR       = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD         = fetch_pkg::c_nop_fill[DATA_WIDTH-1:0],
  parameter                        PROGRAM_FILENAME = "program.hex"
) (
  input wire logic          i_clk,
  input wire logic          i_rst_n,
  instruction_fetch_if.slave bus
);

  import fetch_pkg::*;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch, w_fetch_nxt;
  logic                  r_err;
  logic                  w_err_set;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [DATA_WIDTH-1:0] w_rom_data;
  logic                  w_valid;
  redirect_e             w_kind;
  logic                  w_push, w_pop;
  logic [ADDR_WIDTH-1:0] w_top;
  logic                  w_full, w_empty;

  assign w_valid    = (r_state == ST_RUN);
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_RESET;
      r_addr  <= RESET_ADDR;
      r_fetch <= RESET_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_fetch <= w_fetch_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  // The ROM is addressed with whatever o_addr will be after this edge, so a
  // stall re-reads the same word and the output stays stable.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_fetch_nxt = r_fetch;
    w_rom_addr  = r_addr;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    w_kind      = redirect_select(bus.i_ret, bus.i_call, bus.i_load, w_valid);
    case (w_kind)
      REDIR_RET: begin
        w_state_nxt = ST_BUBBLE;
        w_pop       = !w_empty;
        w_err_set   = w_empty;
        w_fetch_nxt = w_empty ? RESET_ADDR : w_top;
      end
      REDIR_CALL: begin
        w_state_nxt = ST_BUBBLE;
        w_push      = !w_full;
        w_err_set   = w_full;
        w_fetch_nxt = bus.i_addr;
      end
      REDIR_LOAD: begin
        w_state_nxt = ST_BUBBLE;
        w_fetch_nxt = bus.i_addr;
      end
      default: begin
        case (r_state)
          ST_RESET: w_state_nxt = ST_BUBBLE;
          ST_BUBBLE: begin
            w_state_nxt = ST_RUN;
            w_addr_nxt  = r_fetch;
            w_rom_addr  = r_fetch;
          end
          default: begin
            if (!bus.i_stall) begin
              w_addr_nxt = w_addr_inc;
              w_rom_addr = w_addr_inc;
            end
          end
        endcase
      end
    endcase
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_addr_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  ram #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .DATA_WIDTH       (DATA_WIDTH),
    .PROGRAM_FILENAME (PROGRAM_FILENAME)
  ) u_rom (
    .i_clk  (i_clk),
    .i_load (1'b0),
    .i_addr (w_rom_addr),
    .i_data ({DATA_WIDTH{1'b0}}),
    .o_data (w_rom_data)
  );

  assign bus.o_valid       = w_valid;
  assign bus.o_addr        = r_addr;
  assign bus.o_instruction = w_valid ? w_rom_data : NOP_WORD;
  assign bus.o_stack_err   = r_err;

endmodule

`default_nettype wire
